pool_line_buffer: RTL
=====================

Name: pool_line_buffer

Overview:
- Upstream feeder for the 5x5 stride-1 max-pool core.
- Accepts a feature map as a raster pixel stream (valid/ready) and buffers the previous MAXPOOL_SIZE-1 rows in line memories.
- Emits one vertical column of MAXPOOL_SIZE features per cycle, with a pulse strobe, ready for the pool core's horizontal PE chains.
- Inserts "same" padding (pad = 2, pad value = most-negative feature), so the pooled map keeps the input size.

Parameters:
- FEATURE_WIDTH, 16: signed feature width.
- MAXPOOL_SIZE, 5: window size; pad = (MAXPOOL_SIZE-1)/2 = 2.
- MAX_WIDTH, 1024: line-buffer depth, i.e. the largest image width.
- DIM_W, 11: width of the dimension ports.

Ports:
- DSP_clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse; latches img_width and img_height; honoured only in IDLE.
- img_width  in  DIM_W  columns, 1..MAX_WIDTH.
- img_height  in  DIM_W  rows, >=1.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  input pixel accepted when in_valid && in_ready.
- in_feature  in  FEATURE_WIDTH  signed input pixel.
- feature_out  out  FEATURE_WIDTH*MAXPOOL_SIZE  column; slice i (at FEATURE_WIDTH*i) is window row i, 0 = top.
- pulse  out  1  feature_out valid this cycle.
- busy  out  1  high from start until done.
- done  out  1  one-cycle pulse after the last column.

Behaviour:
- Reset values: feature_out=0, pulse=0, in_ready=0, busy=0, done=0, FSM=IDLE, all counters 0. Line memories are not cleared; masking makes stale data unobservable.
- start: accepted only in IDLE with 1<=img_width<=MAX_WIDTH and img_height>=1. Otherwise ignored and FSM stays IDLE. start while busy is ignored.
- Row counter r runs 0..H+1.
  - Rows 0..H-1 are real input rows.
  - Rows H and H+1 are virtual flush rows: pixel value = MIN = -2^(FEATURE_WIDTH-1), and no input is consumed.
- Line buffers lb0..lb3, each MAX_WIDTH deep, read-before-write at column x.
  - Processing column x of row r forms the column {lb0[x], lb1[x], lb2[x], lb3[x], p}.
  - It then writes lb0<=lb1, lb1<=lb2, lb2<=lb3, lb3<=p at address x.
- Vertical masking: slot k represents source row r-4+k. The slot is forced to MIN if r-4+k<0 or r-4+k>H-1.
- Output rows: output row y=r-2 is emitted only while r>=2. Rows 0 and 1 just fill the buffers, with no pulses and no pads.
- FSM states: IDLE, PRE_PAD, ROW, POST_PAD, DONE.
  - IDLE -> ROW on a valid start (r=0). PRE_PAD is skipped when r<2.
  - PRE_PAD: 2 cycles emitting an all-MIN column with pulse=1; in_ready=0.
  - ROW (real row): in_ready=1. Each accepted pixel emits one column; a cycle without in_valid emits nothing.
  - ROW (flush row): one column every cycle; in_ready=0.
  - After column W-1: go to POST_PAD if r>=2, else to the next row.
  - POST_PAD: 2 all-MIN columns with pulse=1; in_ready=0. Then r++; if r==H+2 go to DONE, else go to PRE_PAD (r>=2) or ROW.
  - DONE: done=1 and busy=0 for one cycle, then IDLE.
- Column count: each output row produces exactly W+4 pulses, and there are exactly H output rows. Total pulses = H*(W+4).
- Downstream counts pulses per row; the first 4 pool results of each row are warm-up and are discarded there.
- Latency: feature_out and pulse are registered, valid one cycle after the pixel handshake or pad cycle.
- No output backpressure: pulse is a strobe and downstream must always accept.
- Reset mid-frame: all control is cleared immediately, and the next start begins a clean frame.
- Width/sign: data passes through untouched; only the MIN constant is generated.

Decomposition:
- Shared constants: FEATURE_WIDTH, MAXPOOL_SIZE, and MIN_FEATURE (pad value).
- One sub-module, pool_line_ram: a single-port, read-before-write, MAX_WIDTH x FEATURE_WIDTH memory, instantiated MAXPOOL_SIZE-1 times.
- FSM, counters and masking stay in the top module.

Test Plan:
- W=3, H=3, pixels 1..9 raster, in_valid always high -> 21 pulses.
  - First pulse column (top..bottom) = {MIN, MIN, MIN, MIN, MIN} (pre-pad).
  - Third pulse = {MIN, MIN, 1, 4, 7}.
  - Last real-data column of output row 2 = {3, 6, 9, MIN, MIN}.
  - done pulses exactly once.
- W=1, H=1, pixel 5 -> 5 pulses; the middle one is {MIN, MIN, 5, MIN, MIN}; busy drops together with done.
- Same frame as the first test with in_valid toggling 1010… -> the pulse sequence and data are identical to the first test, just stretched; in_ready=0 during every pad and flush cycle.
- start with img_width=0 or 1025 -> stays IDLE, busy=0, no pulses. Then a legal start works normally.
- Assert rst_n low mid-row 2 of a W=4, H=4 frame -> outputs go to reset values immediately. A new W=2, H=2 frame then yields 12 pulses with no stale data, i.e. MIN wherever rows are out of range.
- start pulsed while busy -> ignored; the running frame's total pulse count is unchanged.

Source files
------------

// File: rtl/pool_line_buffer_pkg.sv
// Shared constants and FSM state encoding for the max-pool line buffer.
//   FEATURE_WIDTH : signed feature width
//   MAXPOOL_SIZE  : pooling window size (odd)
//   MIN_FEATURE   : most-negative feature, used as the padding value
package pool_line_buffer_pkg;

  localparam int FEATURE_WIDTH = 16;
  localparam int MAXPOOL_SIZE  = 5;
  localparam int POOL_PAD      = (MAXPOOL_SIZE - 1) / 2;

  localparam logic [FEATURE_WIDTH-1:0] MIN_FEATURE = {1'b1, {(FEATURE_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE_PAD,
    ST_ROW,
    ST_POST_PAD,
    ST_DONE
  } state_t;

endpackage

// File: rtl/pool_line_ram.sv
// One line memory: single port, asynchronous read, write on the clock edge.
// A read and a write at the same address in one cycle return the old word.
//   DSP_clk : clock
//   we      : write enable
//   addr    : column address
//   wdata   : word to store
//   rdata   : word currently stored at addr
module pool_line_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 1024
) (
  input  logic                     DSP_clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge DSP_clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/pool_line_buffer.sv
// Line buffer feeding the stride-1 max-pool core. Buffers MAXPOOL_SIZE-1 rows
// and emits one vertical window column per strobe, with "same" padding.
//   DSP_clk, rst_n        : clock, async active-low reset
//   start                 : frame start pulse (latches img_width/img_height)
//   img_width, img_height : frame dimensions
//   in_valid/in_ready     : raster pixel handshake, in_feature is the pixel
//   feature_out           : column, slice i is window row i (0 = top)
//   pulse                 : feature_out valid strobe
//   busy, done            : frame in progress / one-cycle completion pulse
//
// state    | meaning
// IDLE     | waiting for a legal start
// PRE_PAD  | PAD all-MIN columns at the left edge of an output row
// ROW      | one column per accepted pixel (real row) or per cycle (flush row)
// POST_PAD | PAD all-MIN columns at the right edge of an output row
// DONE     | one-cycle done pulse
module pool_line_buffer #(
  parameter int FEATURE_WIDTH = pool_line_buffer_pkg::FEATURE_WIDTH,
  parameter int MAXPOOL_SIZE  = pool_line_buffer_pkg::MAXPOOL_SIZE,
  parameter int MAX_WIDTH     = 1024,
  parameter int DIM_W         = 11
) (
  input  logic                                  DSP_clk,
  input  logic                                  rst_n,
  input  logic                                  start,
  input  logic [DIM_W-1:0]                      img_width,
  input  logic [DIM_W-1:0]                      img_height,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [FEATURE_WIDTH-1:0]              in_feature,
  output logic [FEATURE_WIDTH*MAXPOOL_SIZE-1:0] feature_out,
  output logic                                  pulse,
  output logic                                  busy,
  output logic                                  done
);

  import pool_line_buffer_pkg::*;

  localparam int NLB = MAXPOOL_SIZE - 1;
  localparam int PAD = (MAXPOOL_SIZE - 1) / 2;
  localparam int AW  = $clog2(MAX_WIDTH);
  localparam int CW  = DIM_W + 2;
  localparam logic [FEATURE_WIDTH-1:0] MIN_VAL = {1'b1, {(FEATURE_WIDTH-1){1'b0}}};

  state_t             state_q, state_d;
  logic [DIM_W-1:0]   w_q, w_d, h_q, h_d, x_q, x_d;
  logic [DIM_W:0]     r_q, r_d;
  logic [3:0]         pad_q, pad_d;
  logic [CW-1:0]      r_c, h_c;
  logic               real_row, out_row, start_ok, lb_we, emit, emit_pad;
  logic [FEATURE_WIDTH-1:0] src [MAXPOOL_SIZE];
  logic [FEATURE_WIDTH-1:0] col [MAXPOOL_SIZE];
  logic [FEATURE_WIDTH-1:0] lb_rd [NLB];
  logic [FEATURE_WIDTH-1:0] lb_wd [NLB];

  assign r_c      = CW'(r_q);
  assign h_c      = CW'(h_q);
  assign real_row = r_c < h_c;
  assign out_row  = r_c >= CW'(PAD);
  assign start_ok = (img_width != '0) && (int'(img_width) <= MAX_WIDTH) && (img_height != '0);

  // Flush rows feed MIN into the bottom slot without consuming input.
  assign src[NLB] = real_row ? in_feature : MIN_VAL;

  // Each line buffer shifts up by one row at the column being processed.
  for (genvar k = 0; k < NLB; k++) begin : g_lb
    assign src[k]   = lb_rd[k];
    assign lb_wd[k] = src[k+1];
    pool_line_ram #(
      .DATA_W (FEATURE_WIDTH),
      .DEPTH  (MAX_WIDTH)
    ) u_lb (
      .DSP_clk (DSP_clk),
      .we      (lb_we),
      .addr    (x_q[AW-1:0]),
      .wdata   (lb_wd[k]),
      .rdata   (lb_rd[k])
    );
  end

  // Slot k holds source row r-NLB+k; rows outside 0..H-1 read as MIN, which
  // also hides whatever a previous frame left in the line memories.
  always_comb begin
    for (int k = 0; k < MAXPOOL_SIZE; k++) begin
      col[k] = src[k];
      if (emit_pad || (r_c + CW'(k) < CW'(NLB)) || (r_c + CW'(k) > h_c + CW'(NLB - 1)))
        col[k] = MIN_VAL;
    end
  end

  always_ff @(posedge DSP_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      w_q     <= '0;
      h_q     <= '0;
      x_q     <= '0;
      r_q     <= '0;
      pad_q   <= '0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      h_q     <= h_d;
      x_q     <= x_d;
      r_q     <= r_d;
      pad_q   <= pad_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    w_d      = w_q;
    h_d      = h_q;
    x_d      = x_q;
    r_d      = r_q;
    pad_d    = pad_q;
    lb_we    = 1'b0;
    emit     = 1'b0;
    emit_pad = 1'b0;
    in_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && start_ok) begin
          w_d     = img_width;
          h_d     = img_height;
          x_d     = '0;
          r_d     = '0;
          pad_d   = '0;
          state_d = ST_ROW;
        end
      end
      ST_PRE_PAD: begin
        emit     = 1'b1;
        emit_pad = 1'b1;
        if (pad_q == 4'(PAD - 1)) begin
          pad_d   = '0;
          state_d = ST_ROW;
        end else begin
          pad_d = pad_q + 4'd1;
        end
      end
      ST_ROW: begin
        in_ready = real_row;
        if (!real_row || in_valid) begin
          lb_we = 1'b1;
          emit  = out_row;
          if (x_q == w_q - 1'b1) begin
            x_d = '0;
            if (out_row) begin
              pad_d   = '0;
              state_d = ST_POST_PAD;
            end else begin
              r_d     = r_q + 1'b1;
              state_d = (r_c + CW'(1) >= CW'(PAD)) ? ST_PRE_PAD : ST_ROW;
            end
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end
      ST_POST_PAD: begin
        emit     = 1'b1;
        emit_pad = 1'b1;
        if (pad_q == 4'(PAD - 1)) begin
          pad_d   = '0;
          r_d     = r_q + 1'b1;
          state_d = (r_c + CW'(1) == h_c + CW'(PAD)) ? ST_DONE : ST_PRE_PAD;
        end else begin
          pad_d = pad_q + 4'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge DSP_clk or negedge rst_n) begin
    if (!rst_n) begin
      feature_out <= '0;
      pulse       <= 1'b0;
    end else begin
      pulse <= emit;
      if (emit) begin
        for (int k = 0; k < MAXPOOL_SIZE; k++)
          feature_out[k*FEATURE_WIDTH +: FEATURE_WIDTH] <= col[k];
      end
    end
  end

  assign busy = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done = (state_q == ST_DONE);

endmodule
